// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register byte
// offsets relative to BASE, and well-known source indices.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Register byte offsets from BASE.
  localparam logic [4:0] OFF_PEND = 5'h00;
  localparam logic [4:0] OFF_MASK = 5'h04;
  localparam logic [4:0] OFF_CTRL = 5'h08;
  localparam logic [4:0] OFF_ID   = 5'h0C;
  localparam logic [4:0] OFF_CNT0 = 5'h10;

  // Peripheral source indices (lower index = higher priority).
  localparam int SRC_TIMER   = 0;
  localparam int SRC_UART_RX = 1;
  localparam int SRC_UART_TX = 2;

  // Width of the per-source service counters.
  localparam int CNT_W = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over NSRC request bits.
module irq_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] i_req,
  output logic [2:0]      o_idx,
  output logic            o_any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = 3'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: edge-latched sources, mask, global enable,
// and an IDLE/REQ/SERVICE sequencer that drives the CPU's single IRQ line and
// follows the kernel-mode flag through the handler.
// Optional: define IRQ_COUNT_EN to add 8-bit saturating per-source service
// counters at offsets +16 + 4*i.
// The register window is the 32-byte block addr[31:5] == BASE[31:5]; offsets
// are taken modulo 32 from BASE[4:0], so with BASE = 0x40000030 the counters
// wrap to the lower half of the window (0x40000020..0x4000002C).
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NSRC = 4,
  parameter logic [31:0] BASE = 32'h4000_0030
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            ker,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq
);

  localparam logic [2:0] W_PEND = OFF_PEND[4:2];
  localparam logic [2:0] W_MASK = OFF_MASK[4:2];
  localparam logic [2:0] W_CTRL = OFF_CTRL[4:2];
  localparam logic [2:0] W_ID   = OFF_ID[4:2];
  localparam logic [2:0] W_CNT0 = OFF_CNT0[4:2];

  // State
  logic [NSRC-1:0] r_src_q;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_mask;
  logic            r_gen;
  logic            r_id_vld;
  logic [2:0]      r_id;
  logic            r_irq;
  irq_state_e      r_state;

  // Combinational
  irq_state_e      w_state_nxt;
  logic            w_hit;
  logic [4:0]      w_off;
  logic [2:0]      w_word;
  logic            w_wr_pend;
  logic            w_wr_mask;
  logic            w_wr_ctrl;
  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_cand;
  logic [NSRC-1:0] w_win_onehot;
  logic [NSRC-1:0] w_pend_clr;
  logic [2:0]      w_win_idx;
  logic            w_win_any;
  logic            w_capture;
  logic            w_release;
  logic            w_unused_bits;

  assign w_hit     = (addr[31:5] == BASE[31:5]);
  assign w_off     = addr[4:0] - BASE[4:0];
  assign w_word    = w_off[4:2];
  assign w_wr_pend = wr & w_hit & (w_word == W_PEND);
  assign w_wr_mask = wr & w_hit & (w_word == W_MASK);
  assign w_wr_ctrl = wr & w_hit & (w_word == W_CTRL);

  assign w_edge = src & ~r_src_q;
  assign w_cand = r_pend & r_mask & {NSRC{r_gen}};

  // Byte-lane bits of the offset and high write-data bits carry no meaning.
  assign w_unused_bits = ^{wdata, w_off[1:0]};

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio (
    .i_req (w_cand),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  // One-hot form of the winner, used to auto-clear its pending bit.
  always_comb begin
    w_win_onehot = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_win_onehot[i] = w_win_any && (w_win_idx == 3'(i));
    end
  end

  // Pending bits cleared this cycle: software W1C plus service acknowledge.
  always_comb begin
    w_pend_clr = '0;
    if (w_wr_pend) begin
      w_pend_clr = wdata[NSRC-1:0];
    end
    if (w_capture) begin
      w_pend_clr = w_pend_clr | w_win_onehot;
    end
  end

  // Sequencer next state: request only from user mode, capture on kernel entry.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_any && !ker) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!w_win_any) begin
          w_state_nxt = ST_IDLE;
        end else if (ker) begin
          w_state_nxt = ST_SERVICE;
          w_capture   = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (!ker) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state register and registered IRQ (high exactly while in REQ).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= (w_state_nxt == ST_REQ);
    end
  end

  // Edge detect and pending latch; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_src_q <= '0;
      r_pend  <= '0;
    end else begin
      r_src_q <= src;
      r_pend  <= (r_pend & ~w_pend_clr) | w_edge;
    end
  end

  // Software-writable mask and global enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mask <= '0;
      r_gen  <= 1'b0;
    end else begin
      if (w_wr_mask) begin
        r_mask <= wdata[NSRC-1:0];
      end
      if (w_wr_ctrl) begin
        r_gen <= wdata[0];
      end
    end
  end

  // ID register: winner captured on kernel entry, cleared on handler return.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_id_vld <= 1'b0;
      r_id     <= '0;
    end else if (w_capture) begin
      r_id_vld <= 1'b1;
      r_id     <= w_win_idx;
    end else if (w_release) begin
      r_id_vld <= 1'b0;
      r_id     <= '0;
    end
  end

`ifdef IRQ_COUNT_EN
  logic [CNT_W-1:0] r_cnt [NSRC];
  logic [2:0]       w_cnt_sel;
  logic             w_wr_cnt;
  logic [CNT_W-1:0] w_cnt_rd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign w_cnt_sel = w_word - W_CNT0;
  assign w_wr_cnt  = wr & w_hit & w_word[2];

  // Per-source service counters; a write to a counter's offset clears it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (!reset) begin
        r_cnt[i] <= '0;
      end else if (w_wr_cnt && (w_cnt_sel == 3'(i))) begin
        r_cnt[i] <= '0;
      end else if (w_capture && (w_win_idx == 3'(i))) begin
        r_cnt[i] <= sat_inc(r_cnt[i]);
      end
    end
  end

  // Counter read mux; offsets beyond NSRC read 0.
  always_comb begin
    w_cnt_rd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_cnt_sel == 3'(i)) begin
        w_cnt_rd = r_cnt[i];
      end
    end
  end
`endif

  // Zero-wait read mux; anything not addressed reads 0.
  always_comb begin
    rdata = '0;
    if (rd && w_hit) begin
      case (w_word)
        W_PEND:  rdata[NSRC-1:0] = r_pend;
        W_MASK:  rdata[NSRC-1:0] = r_mask;
        W_CTRL:  rdata[0]        = r_gen;
        W_ID: begin
          rdata[31]  = r_id_vld;
          rdata[2:0] = r_id;
        end
        default: begin
`ifdef IRQ_COUNT_EN
          rdata[CNT_W-1:0] = w_cnt_rd;
`endif
        end
      endcase
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: each check pushes its expected value
// when the stimulus is applied and pops it when the DUT output is sampled.
`timescale 1ns/1ps
module tb_irq_controller;

  localparam int          NSRC = 4;
  localparam logic [31:0] BASE = 32'h4000_0030;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] src;
  logic            ker;
  logic            rd;
  logic            wr;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            irq;

  int n_chk;
  int n_pass;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  irq_controller #(
    .NSRC (NSRC),
    .BASE (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .ker   (ker),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_addr(input logic [4:0] off);
    logic [31:0] b;
    logic [4:0]  lo;
    b  = BASE;
    lo = b[4:0] + off;
    return {b[31:5], lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [4:0] off, input logic [31:0] d);
    wr    = 1'b1;
    addr  = reg_addr(off);
    wdata = d;
    tick();
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic en, output logic [31:0] d);
    rd   = en;
    addr = a;
    #1;
    d    = rdata;
    rd   = 1'b0;
    addr = '0;
  endtask

  task automatic exp_rd(input string tag, input logic [4:0] off, input logic [31:0] v);
    exp_t        e;
    logic [31:0] obs;
    sb.push_back('{tag, v});
    bus_rd(reg_addr(off), 1'b1, obs);
    e = sb.pop_front();
    check_eq(e.tag, obs, e.val);
  endtask

  task automatic exp_raw(input string tag, input logic [31:0] a, input logic en,
                         input logic [31:0] v);
    exp_t        e;
    logic [31:0] obs;
    sb.push_back('{tag, v});
    bus_rd(a, en, obs);
    e = sb.pop_front();
    check_eq(e.tag, obs, e.val);
  endtask

  task automatic exp_irq(input string tag, input logic v);
    exp_t e;
    sb.push_back('{tag, {31'd0, v}});
    e = sb.pop_front();
    check_eq(e.tag, {31'd0, irq}, e.val);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    src    = '0;
    ker    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    addr   = '0;
    wdata  = '0;
    tick();
    tick();
    reset = 1'b1;

    // Reset state
    exp_irq("rst_irq", 1'b0);
    exp_rd("rst_pend", 5'h00, 32'h0);
    exp_rd("rst_mask", 5'h04, 32'h0);
    exp_rd("rst_ctrl", 5'h08, 32'h0);
    exp_rd("rst_id",   5'h0C, 32'h0);

    // Basic: src[0] edge to irq in two edges, then service handshake
    bus_wr(5'h04, 32'h1);
    bus_wr(5'h08, 32'h1);
    exp_rd("mask_rb", 5'h04, 32'h1);
    exp_rd("ctrl_rb", 5'h08, 32'h1);
    src = 4'b0001;
    tick();
    src = 4'b0000;
    exp_irq("basic_irq_e0", 1'b0);
    exp_rd("basic_pend", 5'h00, 32'h1);
    tick();
    exp_irq("basic_irq_e1", 1'b1);
    ker = 1'b1;
    tick();
    exp_irq("basic_irq_svc", 1'b0);
    exp_rd("basic_id", 5'h0C, 32'h8000_0000);
    exp_rd("basic_pend_clr", 5'h00, 32'h0);
    tick();
    exp_irq("basic_irq_hold", 1'b0);
    ker = 1'b0;
    tick();
    exp_rd("basic_id_ret", 5'h0C, 32'h0);
    exp_irq("basic_irq_ret", 1'b0);

    // Priority: simultaneous events on src[2] and src[1]
    bus_wr(5'h04, 32'hF);
    src = 4'b0110;
    tick();
    src = 4'b0000;
    tick();
    exp_irq("prio_irq", 1'b1);
    exp_rd("prio_pend", 5'h00, 32'h6);
    ker = 1'b1;
    tick();
    exp_rd("prio_id1", 5'h0C, 32'h8000_0001);
    exp_rd("prio_pend_left", 5'h00, 32'h4);
    ker = 1'b0;
    tick();
    exp_irq("prio_idle_gap", 1'b0);
    tick();
    exp_irq("prio_irq2", 1'b1);
    ker = 1'b1;
    tick();
    exp_rd("prio_id2", 5'h0C, 32'h8000_0002);
    exp_rd("prio_pend_empty", 5'h00, 32'h0);
    ker = 1'b0;
    tick();

    // Kernel entry from IDLE never enters SERVICE
    ker = 1'b1;
    src = 4'b1000;
    tick();
    src = 4'b0000;
    tick();
    tick();
    exp_irq("ker_idle_irq", 1'b0);
    exp_rd("ker_idle_id", 5'h0C, 32'h0);
    ker = 1'b0;
    tick();

    // Withdraw: mask removed while requesting
    exp_irq("wd_irq", 1'b1);
    bus_wr(5'h04, 32'h0);
    exp_irq("wd_irq_write_edge", 1'b1);
    tick();
    exp_irq("wd_irq_fall", 1'b0);
    exp_rd("wd_pend_kept", 5'h00, 32'h8);
    bus_wr(5'h04, 32'hF);
    exp_irq("wd_irq_mask_edge", 1'b0);
    tick();
    exp_irq("wd_irq_rise", 1'b1);
    bus_wr(5'h00, 32'h8);
    tick();
    exp_irq("wd_irq_w1c", 1'b0);
    exp_rd("wd_pend_w1c", 5'h00, 32'h0);

    // Collision: W1C of PEND[0] together with a new src[0] edge
    bus_wr(5'h08, 32'h0);
    src = 4'b0001;
    tick();
    src = 4'b0000;
    tick();
    exp_rd("col_pend_pre", 5'h00, 32'h1);
    src   = 4'b0001;
    wr    = 1'b1;
    addr  = reg_addr(5'h00);
    wdata = 32'h1;
    tick();
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    src   = 4'b0000;
    exp_rd("col_pend_setwins", 5'h00, 32'h1);
    exp_raw("rd_low_zero", reg_addr(5'h00), 1'b0, 32'h0);
    exp_raw("addr_miss_zero", BASE + 32'h20, 1'b1, 32'h0);
    exp_irq("col_gen_off_irq", 1'b0);
    tick();
    bus_wr(5'h00, 32'h1);
    exp_rd("col_pend_w1c", 5'h00, 32'h0);

    // Reset in SERVICE with PEND=6 left behind
    bus_wr(5'h08, 32'h1);
    src = 4'b0111;
    tick();
    src = 4'b0000;
    tick();
    exp_irq("rst2_req", 1'b1);
    ker = 1'b1;
    tick();
    exp_rd("rst2_pend_pre", 5'h00, 32'h6);
    exp_rd("rst2_id_pre", 5'h0C, 32'h8000_0000);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ker   = 1'b0;
    exp_irq("rst2_irq", 1'b0);
    exp_rd("rst2_pend", 5'h00, 32'h0);
    exp_rd("rst2_mask", 5'h04, 32'h0);
    exp_rd("rst2_ctrl", 5'h08, 32'h0);
    exp_rd("rst2_id",   5'h0C, 32'h0);
`ifdef IRQ_COUNT_EN
    exp_rd("rst2_cnt0", 5'h10, 32'h0);

    // Counter saturation over 300 service rounds on src[0]
    bus_wr(5'h04, 32'h1);
    bus_wr(5'h08, 32'h1);
    for (int r = 0; r < 300; r++) begin
      src = 4'b0001;
      tick();
      src = 4'b0000;
      tick();
      ker = 1'b1;
      tick();
      ker = 1'b0;
      tick();
    end
    exp_rd("cnt0_sat", 5'h10, 32'd255);
    exp_rd("cnt1_idle", 5'h14, 32'd0);
    bus_wr(5'h10, 32'h0);
    exp_rd("cnt0_clr", 5'h10, 32'd0);
`else
    // Without counters those offsets read 0 and ignore writes
    bus_wr(5'h04, 32'h1);
    bus_wr(5'h08, 32'h1);
    src = 4'b0001;
    tick();
    src = 4'b0000;
    tick();
    ker = 1'b1;
    tick();
    ker = 1'b0;
    tick();
    exp_rd("nocnt_rd", 5'h10, 32'h0);
    bus_wr(5'h10, 32'hFF);
    exp_rd("nocnt_wr", 5'h10, 32'h0);
    exp_rd("nocnt_mask_intact", 5'h04, 32'h1);
`endif

    if (sb.size() != 0) begin
      check_eq("sb_drained", 32'(sb.size()), 32'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
